// File: rtl/debounce_counter.sv
// Debounce timing stage: while the change latch reports a pending change,
// waits for COUNT_MAX consecutive stable cycles of sig_sync, then commits the
// captured level to db_out, strobes rise/fall, and pulses count_finished.
module debounce_counter #(
    parameter int unsigned COUNT_MAX   = 50000,
    parameter int unsigned CNT_WIDTH   = 16,
    parameter logic        RESET_LEVEL = 1'b0
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sig_sync,
    input  logic                 state,
    output logic                 count_finished,
    output logic                 db_out,
    output logic                 rise_pulse,
    output logic                 fall_pulse,
    output logic [CNT_WIDTH-1:0] cnt
);

    localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(COUNT_MAX - 1);
    localparam logic [CNT_WIDTH-1:0] CNT_ZERO = '0;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        COUNT = 2'd1,
        DONE  = 2'd2
    } fsm_t;

    fsm_t                 fsm_q;
    fsm_t                 fsm_nxt;
    logic [CNT_WIDTH-1:0] cnt_nxt;
    logic                 captured;
    logic                 captured_nxt;
    logic                 db_nxt;
    logic                 finished_nxt;
    logic                 rise_nxt;
    logic                 fall_nxt;

    // State and registered outputs; async reset forces every reset value at once
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_q          <= IDLE;
            cnt            <= CNT_ZERO;
            captured       <= RESET_LEVEL;
            db_out         <= RESET_LEVEL;
            count_finished <= 1'b0;
            rise_pulse     <= 1'b0;
            fall_pulse     <= 1'b0;
        end else begin
            fsm_q          <= fsm_nxt;
            cnt            <= cnt_nxt;
            captured       <= captured_nxt;
            db_out         <= db_nxt;
            count_finished <= finished_nxt;
            rise_pulse     <= rise_nxt;
            fall_pulse     <= fall_nxt;
        end
    end

    // Next-state and next-output logic; pulses default low so they last one cycle
    always_comb begin
        fsm_nxt      = fsm_q;
        cnt_nxt      = cnt;
        captured_nxt = captured;
        db_nxt       = db_out;
        finished_nxt = 1'b0;
        rise_nxt     = 1'b0;
        fall_nxt     = 1'b0;

        case (fsm_q)
            IDLE: begin
                cnt_nxt = CNT_ZERO;
                if (state) begin
                    fsm_nxt      = COUNT;
                    captured_nxt = sig_sync;
                end
            end

            COUNT: begin
                if (!state) begin
                    // latch dropped the request: abandon the window silently
                    fsm_nxt = IDLE;
                    cnt_nxt = CNT_ZERO;
                end else if (sig_sync != captured) begin
                    // bounce: restart the window on the new level
                    cnt_nxt      = CNT_ZERO;
                    captured_nxt = sig_sync;
                end else if (cnt == CNT_LAST) begin
                    // window complete: cnt is left at CNT_LAST, never wraps
                    fsm_nxt      = DONE;
                    finished_nxt = 1'b1;
                    db_nxt       = captured;
                    rise_nxt     = captured & ~db_out;
                    fall_nxt     = ~captured & db_out;
                end else begin
                    cnt_nxt = cnt + CNT_ONE;
                end
            end

            DONE: begin
                // state is ignored here: the latch clears it on this edge
                fsm_nxt = IDLE;
                cnt_nxt = CNT_ZERO;
            end

            default: begin
                fsm_nxt = IDLE;
                cnt_nxt = CNT_ZERO;
            end
        endcase
    end

endmodule

// File: tb/tb_debounce_counter.sv
// Bench for debounce_counter: directed scenarios with literal expectations,
// then randomized bouncing input driven through a small change-latch emulation,
// all checked every cycle against a timestamp-based model of the window rules.
module tb_debounce_counter;

    localparam int unsigned CM = 4;
    localparam int unsigned CW = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          sig_sync = 1'b0;
    logic          state = 1'b0;
    logic          count_finished;
    logic          db_out;
    logic          rise_pulse;
    logic          fall_pulse;
    logic [CW-1:0] cnt;

    int checks = 0;
    int failures = 0;
    bit run = 1'b0;

    debounce_counter #(
        .COUNT_MAX  (CM),
        .CNT_WIDTH  (CW),
        .RESET_LEVEL(1'b0)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .sig_sync      (sig_sync),
        .state         (state),
        .count_finished(count_finished),
        .db_out        (db_out),
        .rise_pulse    (rise_pulse),
        .fall_pulse    (fall_pulse),
        .cnt           (cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks = checks + 1;
        if (act != exp) begin
            failures = failures + 1;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: a window is an interval of edges; t0 is the edge where the current
    // stable run began. The run completes when CM edges have passed since t0.
    int cyc = 0;
    int phase = 0;      // 0 idle, 1 window open, 2 completion cycle
    int t0 = 0;
    bit lvl = 1'b0;
    bit m_db = 1'b0;
    bit m_rise = 1'b0;
    bit m_fall = 1'b0;

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            cyc    <= 0;
            phase  <= 0;
            t0     <= 0;
            lvl    <= 1'b0;
            m_db   <= 1'b0;
            m_rise <= 1'b0;
            m_fall <= 1'b0;
        end else begin
            cyc <= cyc + 1;
            case (phase)
                0: if (state) begin
                    phase <= 1;
                    t0    <= cyc + 1;
                    lvl   <= sig_sync;
                end
                1: begin
                    if (!state) begin
                        phase <= 0;
                    end else if (sig_sync != lvl) begin
                        t0  <= cyc + 1;
                        lvl <= sig_sync;
                    end else if ((cyc + 1) - t0 == int'(CM)) begin
                        phase  <= 2;
                        m_rise <= lvl && !m_db;
                        m_fall <= !lvl && m_db;
                        m_db   <= lvl;
                    end
                end
                default: phase <= 0;
            endcase
        end
    end

    // Per-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        if (run && !reset) begin
            int exp_cnt;
            exp_cnt = (phase == 1) ? (cyc - t0) : (phase == 2) ? int'(CM) - 1 : 0;
            chk("cnt", int'(cnt), exp_cnt);
            chk("count_finished", int'(count_finished), int'(phase == 2));
            chk("db_out", int'(db_out), int'(m_db));
            chk("rise_pulse", int'(rise_pulse), int'(phase == 2 && m_rise));
            chk("fall_pulse", int'(fall_pulse), int'(phase == 2 && m_fall));
            chk("rise_and_fall", int'(rise_pulse & fall_pulse), 0);
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic expect_out(input string tag, input int c, input int cf, input int db,
                              input int r, input int f);
        chk({tag, ".cnt"}, int'(cnt), c);
        chk({tag, ".cf"}, int'(count_finished), cf);
        chk({tag, ".db"}, int'(db_out), db);
        chk({tag, ".rise"}, int'(rise_pulse), r);
        chk({tag, ".fall"}, int'(fall_pulse), f);
    endtask

    initial begin
        int rcount;
        rcount = 0;
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #2;
        expect_out("reset", 0, 0, 0, 0, 0);
        reset = 1'b0;
        run = 1'b1;
        tick();

        // S1: stable 1 with state high -> rise after CM+1 edges
        sig_sync = 1'b1; state = 1'b1;
        for (int i = 0; i < int'(CM); i++) begin
            tick();
            expect_out("s1.count", i, 0, 0, 0, 0);
        end
        tick();
        expect_out("s1.done", int'(CM) - 1, 1, 1, 1, 0);
        state = 1'b0;
        tick();
        expect_out("s1.idle", 0, 0, 1, 0, 0);

        // S3: one-cycle glitch to 0 while db_out=1 -> completes on 1, no strobe
        sig_sync = 1'b0; state = 1'b1;
        tick();
        expect_out("s3.cap", 0, 0, 1, 0, 0);
        sig_sync = 1'b1;
        tick();
        expect_out("s3.bounce", 0, 0, 1, 0, 0);
        for (int i = 1; i < int'(CM); i++) begin
            tick();
            chk("s3.cnt", int'(cnt), i);
        end
        tick();
        expect_out("s3.done", int'(CM) - 1, 1, 1, 0, 0);
        state = 1'b0;
        tick();

        // S4: stable 0 while db_out=1 -> fall strobe
        sig_sync = 1'b0; state = 1'b1;
        repeat (CM) tick();
        chk("s4.pre_cf", int'(count_finished), 0);
        tick();
        expect_out("s4.done", int'(CM) - 1, 1, 0, 0, 1);
        state = 1'b0;
        tick();
        expect_out("s4.idle", 0, 0, 0, 0, 0);

        // S2: toggles at COUNT cycles 2 and 3 restart the window twice
        sig_sync = 1'b1; state = 1'b1;
        tick(); tick();
        chk("s2.cnt1", int'(cnt), 1);
        sig_sync = 1'b0;
        tick();
        chk("s2.restart1", int'(cnt), 0);
        sig_sync = 1'b1;
        tick();
        chk("s2.restart2", int'(cnt), 0);
        repeat (CM - 1) tick();
        chk("s2.pre_cf", int'(count_finished), 0);
        tick();
        expect_out("s2.done", int'(CM) - 1, 1, 1, 1, 0);
        state = 1'b0;
        tick();

        // S6: state drops mid-window -> idle, no pulse, db_out kept
        sig_sync = 1'b0; state = 1'b1;
        tick(); tick();
        chk("s6.cnt1", int'(cnt), 1);
        state = 1'b0;
        tick();
        expect_out("s6.drop", 0, 0, 1, 0, 0);
        tick();
        expect_out("s6.after", 0, 0, 1, 0, 0);

        // S5: async reset mid-window at cnt=2 takes effect immediately
        state = 1'b1;
        tick(); tick(); tick();
        chk("s5.cnt2", int'(cnt), 2);
        #1 reset = 1'b1;
        #1;
        expect_out("s5.reset", 0, 0, 0, 0, 0);
        state = 1'b0;
        tick();
        reset = 1'b0;
        repeat (CM + 2) begin
            tick();
            chk("s5.no_cf", int'(count_finished), 0);
        end

        // Random phase: bouncing input through an emulated change latch
        for (int n = 0; n < 4000; n++) begin
            @(posedge clk);
            #1;
            if ($urandom_range(0, 599) == 0) begin
                reset = 1'b1;
                rcount++;
                #1;
                expect_out("rand.reset", 0, 0, 0, 0, 0);
                state = 1'b0;
                @(posedge clk);
                #1;
                reset = 1'b0;
            end
            if ($urandom_range(0, 7) == 0) sig_sync = ~sig_sync;
            if (count_finished) state = 1'b0;
            else if (sig_sync != db_out) state = 1'b1;
            if ($urandom_range(0, 49) == 0) state = ~state;
        end

        tick();
        run = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
